// File: rtl/axis_pipeline_shim.sv
// axis_pipeline_shim: valid/ready shim around a fixed-latency, non-stallable core,
// with a credit-guarded first-word fall-through result FIFO.
module axis_pipeline_shim #(
   parameter int DATA_WIDTH = 64,
   parameter int FIFO_DEPTH = 8,
   localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] core_data_o,
   output logic                  core_valid_o,
   input  logic [DATA_WIDTH-1:0] core_data_i,
   input  logic                  core_valid_i,
   output logic [CW-1:0]         credits_o,
   output logic [CW-1:0]         fill_o,
   output logic                  overflow_o
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]         wptr, rptr;
   logic [CW-1:0]         credits, fill;
   logic                  acc, pop, full, wr;

   // A pop on the same edge frees the slot a full-FIFO write needs.
   always_comb begin
      s_ready = reset & (credits != '0);
      acc     = s_valid & s_ready;
      m_valid = fill != '0;
      m_data  = mem[rptr];
      pop     = m_valid & m_ready;
      full    = fill == DEPTH;
      wr      = core_valid_i & (~full | pop);
   end

   assign credits_o = credits;
   assign fill_o    = fill;

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         core_valid_o <= 1'b0;
         core_data_o  <= '0;
         wptr         <= '0;
         rptr         <= '0;
         fill         <= '0;
         credits      <= DEPTH;
         overflow_o   <= 1'b0;
      end else begin
         core_valid_o <= acc;
         if (acc) core_data_o <= s_data;
         if (wr) wptr <= wptr + AW'(1);
         if (pop) rptr <= rptr + AW'(1);
         if (wr != pop) fill <= wr ? fill + CW'(1) : fill - CW'(1);
         // Clamp keeps a spurious core result from inflating credits past the depth.
         if (acc && !pop) credits <= credits - CW'(1);
         else if (pop && !acc && credits != DEPTH) credits <= credits + CW'(1);
         if (core_valid_i && !wr) overflow_o <= 1'b1;
      end

   always_ff @(posedge clk)
      if (wr) mem[wptr] <= core_data_i;
endmodule

// File: tb/tb_axis_pipeline_shim.sv
// tb_axis_pipeline_shim: directed bench with a 3-cycle pass-through core model
// and an in-order scoreboard of accepted words.
module tb_axis_pipeline_shim;
   logic        clk, reset;
   logic [63:0] s_data, m_data, core_data_o, core_data_i, inj_d;
   logic        s_valid, s_ready, m_valid, m_ready, core_valid_o, core_valid_i, inj_v;
   logic [3:0]  credits_o, fill_o;
   logic        overflow_o;
   logic [2:0]  pv;
   logic [63:0] pd [3];
   logic [63:0] exp_q [$];
   int          n_checks = 0, n_fail = 0, rx_cnt = 0;

   axis_pipeline_shim #(.DATA_WIDTH(64), .FIFO_DEPTH(8)) dut (
      .clk(clk), .reset(reset),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .core_data_o(core_data_o), .core_valid_o(core_valid_o),
      .core_data_i(core_data_i), .core_valid_i(core_valid_i),
      .credits_o(credits_o), .fill_o(fill_o), .overflow_o(overflow_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Core model: L=3 identity pipeline, reset with the shim; inj_v forces a spurious result.
   always @(posedge clk or negedge reset)
      if (!reset) pv <= '0;
      else begin
         pv    <= {pv[1:0], core_valid_o};
         pd[0] <= core_data_o;
         pd[1] <= pd[0];
         pd[2] <= pd[1];
      end
   assign core_valid_i = pv[2] | inj_v;
   assign core_data_i  = inj_v ? inj_d : pd[2];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk)
      if (!reset) exp_q.delete();
      else begin
         if (m_valid && m_ready) begin
            check("rx_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) check("rx_order", m_data, exp_q.pop_front());
            rx_cnt++;
         end
         if (s_valid && s_ready) exp_q.push_back(s_data);
      end

   task automatic single(input logic [63:0] d);
      int cyc;
      s_data = d; s_valid = 1'b1; m_ready = 1'b1;
      tick();
      s_valid = 1'b0;
      check("req_valid", core_valid_o, 1);
      check("req_data", core_data_o, d);
      check("credit_take", credits_o, 7);
      cyc = 1;
      while (!m_valid && cyc < 20) begin
         tick();
         cyc++;
      end
      check("latency", cyc, 5);
      check("single_data", m_data, d);
      tick();
      check("credit_back", credits_o, 8);
      check("single_empty", m_valid, 0);
   endtask

   initial begin
      int i, lows, seen, first_c, last_c, rx0;
      logic a;
      reset = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0; inj_v = 1'b0; inj_d = '0;
      #1 reset = 1'b0;
      #2;
      check("rst_s_ready", s_ready, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_core_valid", core_valid_o, 0);
      check("rst_core_data", core_data_o, 0);
      check("rst_credits", credits_o, 8);
      check("rst_fill", fill_o, 0);
      check("rst_overflow", overflow_o, 0);
      tick(); tick();
      reset = 1'b1;
      #1 check("rel_s_ready", s_ready, 1);

      single(64'hDEAD_BEEF);

      m_ready = 1'b1; i = 0; lows = 0; seen = 0; first_c = -1; last_c = -1; rx0 = rx_cnt;
      for (int c = 0; c < 130; c++) begin
         s_valid = i < 100;
         s_data = 64'(1000 + i);
         if (s_valid && !s_ready) lows++;
         a = s_valid & s_ready;
         tick();
         if (a) i++;
         if (m_valid) begin
            seen++;
            if (first_c < 0) first_c = c;
            last_c = c;
         end
      end
      s_valid = 1'b0;
      check("stream_sent", i, 100);
      check("stream_ready_low", lows, 0);
      check("stream_seen", seen, 100);
      check("stream_gapfree", last_c - first_c, 99);
      check("stream_rx", rx_cnt - rx0, 100);

      m_ready = 1'b0; i = 0; rx0 = rx_cnt;
      for (int c = 0; c < 40; c++) begin
         s_valid = i < 20;
         s_data = 64'(2000 + i);
         a = s_valid & s_ready;
         tick();
         if (a) begin
            i++;
            if (i == 8) check("bp_ready_drop", s_ready, 0);
         end
      end
      s_valid = 1'b0;
      check("bp_accepted", i, 8);
      check("bp_fill", fill_o, 8);
      check("bp_credits", credits_o, 0);
      check("bp_overflow", overflow_o, 0);
      check("bp_head", m_data, 2000);

      m_ready = 1'b1; inj_v = 1'b1; inj_d = 64'hAAAA; exp_q.push_back(64'hAAAA);
      tick();
      inj_v = 1'b0;
      check("full_popwr_fill", fill_o, 8);
      check("full_popwr_ovf", overflow_o, 0);
      check("full_popwr_head", m_data, 2001);

      s_valid = 1'b1; s_data = 64'd2008; m_ready = 1'b1;
      check("accpop_ready", s_ready, 1);
      tick();
      s_valid = 1'b0; m_ready = 1'b0; i = 9;
      check("accpop_credits", credits_o, 1);
      check("accpop_fill", fill_o, 7);
      repeat (5) tick();
      check("refill", fill_o, 8);

      inj_v = 1'b1; inj_d = 64'hBAD;
      tick();
      inj_v = 1'b0;
      check("ovf_set", overflow_o, 1);
      check("ovf_fill", fill_o, 8);
      check("ovf_head", m_data, 2002);
      repeat (3) tick();
      check("ovf_sticky", overflow_o, 1);

      m_ready = 1'b1;
      for (int c = 0; c < 60; c++) begin
         s_valid = i < 20;
         s_data = 64'(2000 + i);
         a = s_valid & s_ready;
         tick();
         if (a) i++;
      end
      s_valid = 1'b0;
      check("drain_sent", i, 20);
      check("drain_fill", fill_o, 0);
      check("drain_credits", credits_o, 8);
      check("drain_rx", rx_cnt - rx0, 21);
      check("drain_q_empty", exp_q.size(), 0);

      m_ready = 1'b0;
      for (int j = 0; j < 5; j++) begin
         s_valid = 1'b1;
         s_data = 64'(3000 + j);
         tick();
      end
      s_valid = 1'b0;
      tick();
      check("mid_fill", fill_o, 2);
      #2 reset = 1'b0;
      #1;
      check("arst_core_valid", core_valid_o, 0);
      check("arst_core_data", core_data_o, 0);
      check("arst_s_ready", s_ready, 0);
      check("arst_m_valid", m_valid, 0);
      check("arst_credits", credits_o, 8);
      check("arst_fill", fill_o, 0);
      check("arst_overflow", overflow_o, 0);
      tick(); tick();
      reset = 1'b1;
      #1;
      check("post_rst_ready", s_ready, 1);
      check("post_rst_credits", credits_o, 8);
      single(64'h1234_5678);
      repeat (6) tick();
      check("post_rst_quiet", m_valid, 0);
      check("post_rst_ovf", overflow_o, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
